// File: rtl/riscv_pkg.sv
// Shared constants for the RV32 instruction-fetch front end.
package riscv_pkg;

    localparam int          DEFAULT_XLEN     = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    // Occupancy counters carry one extra bit so that DEPTH itself is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO with synchronous flush, used for fetched words and for request PC tags.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [WIDTH-1:0]       o_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rptr];

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: issues credit-limited imem requests, buffers returned words
// with their PCs, and presents them in order to the IF/ID register.
module if_fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN     = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            valid_IF,
    output logic [XLEN-1:0] PC_IF,
    output logic [31:0]     instr_IF
);

    localparam int CW = cnt_width(DEPTH);
    localparam int SW = CW + 1;
    localparam int EW = XLEN + 32;

    logic            r_rst_q;
    logic [XLEN-1:0] r_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop;

    logic            w_accept;
    logic            w_resp;
    logic            w_keep;
    logic            w_pop;
    logic [CW-1:0]   w_outstanding_next;
    logic [SW-1:0]   w_credit_used;
    logic [CW-1:0]   w_fifo_count;
    logic [CW-1:0]   w_unused_tag_count;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic            w_tag_full;
    logic            w_tag_empty;
    logic [EW-1:0]   w_head;
    logic [XLEN-1:0] w_tag_pc;

    assign w_credit_used = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
    assign imem_req  = !r_rst_q && (w_credit_used < SW'(DEPTH)) && !w_fifo_full && !w_tag_full;
    assign imem_addr = r_pc;

    assign w_accept = imem_req && imem_gnt;
    assign w_resp   = imem_rvalid && (r_outstanding != '0);
    // Dropped responses belong to requests whose tags were flushed, so they leave the tag queue alone.
    assign w_keep   = w_resp && (r_drop == '0) && !w_tag_empty;
    assign w_pop    = valid_IF && !stall;
    assign w_outstanding_next = r_outstanding + CW'(w_accept) - CW'(w_resp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rst_q       <= 1'b1;
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            r_rst_q       <= 1'b0;
            r_outstanding <= w_outstanding_next;
            if (redirect_valid) begin
                r_pc   <= redirect_pc & ~XLEN'(3);
                r_drop <= w_outstanding_next;
            end else begin
                if (w_accept) r_pc <= r_pc + XLEN'(4);
                if (w_resp && (r_drop != '0)) r_drop <= r_drop - 1'b1;
            end
        end
    end

    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_tag_queue (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_accept),
        .i_data  (r_pc),
        .i_pop   (w_keep),
        .i_flush (redirect_valid),
        .o_data  (w_tag_pc),
        .o_count (w_unused_tag_count),
        .o_full  (w_tag_full),
        .o_empty (w_tag_empty)
    );

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_word_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_keep),
        .i_data  ({w_tag_pc, imem_rdata}),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_data  (w_head),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign valid_IF = !w_fifo_empty;
    assign PC_IF    = valid_IF ? w_head[EW-1:32] : '0;
    assign instr_IF = valid_IF ? w_head[31:0] : NOP_INSTR;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: a memory responder plus a program-order model of the PC stream.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        valid_IF;
    logic [31:0] PC_IF;
    logic [31:0] instr_IF;

    always #5 clk = ~clk;

    if_fetch_unit #(
        .XLEN     (32),
        .RESET_PC (RESET_PC),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .valid_IF       (valid_IF),
        .PC_IF          (PC_IF),
        .instr_IF       (instr_IF)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    int          checks = 0;
    int          failures = 0;
    int          cycle = 0;
    int          lastDue = 0;
    int          consumed = 0;
    int          gntPct = 100;
    int          latMin = 1;
    int          latMax = 1;
    bit          stallIn = 1'b0;
    bit          prevRedir = 1'b0;
    logic [31:0] expPc = RESET_PC;
    logic [31:0] lastPc = '0;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: check what the consumer sees, answer imem, drive inputs, advance to next negedge.
    task automatic applyStimulus(input bit redir, input logic [31:0] rpc);
        pend_t p;
        int    lat;
        if (prevRedir) checkOutput("valid_after_redirect", 64'(valid_IF), 64'(0));
        if (valid_IF && !stallIn && !redir) begin
            checkOutput("pc_order", 64'(PC_IF), 64'(expPc));
            checkOutput("instr_word", 64'(instr_IF), 64'(memWord(expPc)));
            lastPc = PC_IF;
            expPc  = expPc + 32'd4;
            consumed++;
        end else if (!valid_IF) begin
            checkOutput("idle_nop", {PC_IF, instr_IF}, {32'h0, NOP});
        end
        if (redir) expPc = rpc & ~32'h3;
        if (imem_req) checkOutput("addr_aligned", 64'(imem_addr[1:0]), 64'(0));

        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (pend.size() > 0 && pend[0].due <= cycle) begin
            p = pend.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = memWord(p.addr);
        end
        imem_gnt = ($urandom_range(99) < gntPct);
        if (imem_req && imem_gnt) begin
            lat     = $urandom_range(latMax, latMin);
            p.addr  = imem_addr;
            p.due   = (cycle + lat > lastDue) ? cycle + lat : lastDue + 1;
            lastDue = p.due;
            pend.push_back(p);
        end
        stall          = stallIn;
        redirect_valid = redir;
        redirect_pc    = rpc;
        prevRedir      = redir;
        @(negedge clk);
        cycle++;
    endtask

    task automatic runUntilConsumed(input int n, input int budget, input string tag);
        int start = consumed;
        int spent = 0;
        while ((consumed - start < n) && (spent < budget)) begin
            applyStimulus(1'b0, '0);
            spent++;
        end
        checkOutput(tag, 64'(consumed - start), 64'(n));
    endtask

    task automatic runUntilPending(input int n, input int budget, input string tag);
        int spent = 0;
        while ((pend.size() != n) && (spent < budget)) begin
            applyStimulus(1'b0, '0);
            spent++;
        end
        checkOutput(tag, 64'(pend.size()), 64'(n));
    endtask

    task automatic applyReset(input bit lateRsp);
        rst            = 1'b1;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        #1;
        checkOutput("rst_async_req", 64'(imem_req), 64'(0));
        checkOutput("rst_async_valid", 64'(valid_IF), 64'(0));
        @(negedge clk);
        cycle++;
        checkOutput("rst_outputs", {PC_IF, instr_IF}, {32'h0, NOP});
        checkOutput("rst_addr", 64'(imem_addr), 64'(RESET_PC));
        @(negedge clk);
        cycle++;
        pend.delete();
        lastDue   = cycle;
        expPc     = RESET_PC;
        prevRedir = 1'b0;
        stallIn   = 1'b0;
        rst         = 1'b0;
        imem_rvalid = lateRsp;
        imem_rdata  = $urandom;
        @(negedge clk);
        cycle++;
        imem_rvalid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int start;
        int guard;
        logic [31:0] rpc;
        bit redir;

        #1;
        applyReset(1'b0);

        $display("[TB] sequential fetch, gnt always, 1-cycle rvalid");
        gntPct = 100; latMin = 1; latMax = 1;
        runUntilConsumed(12, 60, "s1_stream");
        checkOutput("s1_last_pc", 64'(lastPc), 64'(32'h2C));

        $display("[TB] stall with full buffer");
        stallIn = 1'b1;
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("s2_req_low", 64'(imem_req), 64'(0));
            checkOutput("s2_valid_held", 64'(valid_IF), 64'(1));
            checkOutput("s2_pc_held", 64'(PC_IF), 64'(expPc));
            checkOutput("s2_instr_held", 64'(instr_IF), 64'(memWord(expPc)));
            applyStimulus(1'b0, '0);
        end
        stallIn = 1'b0;
        runUntilConsumed(4, 20, "s2_resume");

        $display("[TB] redirect with two requests in flight");
        latMin = 3; latMax = 3;
        runUntilPending(2, 30, "s3_two_pending");
        applyStimulus(1'b1, 32'h100);
        runUntilConsumed(1, 30, "s3_refetch");
        checkOutput("s3_first_pc", 64'(lastPc), 64'(32'h100));

        $display("[TB] redirect coinciding with grant, unaligned target");
        latMin = 1; latMax = 1;
        guard = 0;
        while (!imem_req && guard < 10) begin
            applyStimulus(1'b0, '0);
            guard++;
        end
        checkOutput("s4_req_seen", 64'(imem_req), 64'(1));
        applyStimulus(1'b1, 32'h203);
        checkOutput("s4_addr_reloaded", 64'(imem_addr), 64'(32'h200));
        runUntilConsumed(1, 30, "s4_refetch");
        checkOutput("s4_first_pc", 64'(lastPc), 64'(32'h200));

        $display("[TB] random grant, latency, stall and redirect");
        gntPct = 50; latMin = 1; latMax = 3;
        start = consumed;
        for (int i = 0; i < 400; i++) begin
            stallIn = ($urandom_range(3) == 0);
            redir   = ($urandom_range(19) == 0);
            rpc     = $urandom & 32'h0000_FFFF;
            applyStimulus(redir, rpc);
        end
        checkOutput("s5_progress", 64'(consumed - start >= 40), 64'(1));
        stallIn = 1'b0;
        runUntilConsumed(3, 60, "s5_drain");

        $display("[TB] reset with requests in flight, then a late response");
        gntPct = 100; latMin = 3; latMax = 3;
        runUntilPending(2, 30, "s6_two_pending");
        applyReset(1'b1);
        latMin = 1; latMax = 1;
        runUntilConsumed(1, 30, "s6_restart");
        checkOutput("s6_first_pc", 64'(lastPc), 64'(RESET_PC));
        runUntilConsumed(4, 30, "s6_stream");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
